// File: rtl/f1_sequencer.sv
// f1_sequencer -- controller for the F1 start-light FSM.
//
// When it sees a start request it clears the light FSM, then advances it one
// light per tick until all eight lights are lit. It holds them for a
// pseudo-random number of ticks, then sends a ninth advance so the light FSM
// wraps to all-off. From that point it counts clock cycles until the driver
// presses the button.
//
// Parameters:
//   TICK_DIV     clock cycles per light step and per hold unit (>= 2)
//   REACT_W      width of the reaction counter and result
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   trigger      start request, level-sampled, honoured only when idle
//   press        driver button, synchronous to clk
//   light_en     one-cycle pulse: advance the light FSM by one state
//   light_clr    one-cycle pulse: clear the light FSM to all-off
//   busy         high whenever a sequence is in progress
//   react_valid  one-cycle pulse; react_time updates in the same cycle
//   react_time   last measured reaction time in cycles, saturating
//   jump_start   one-cycle pulse when an early press aborts a sequence
//
// Build option: define F1_SEQ_JUMP_START_EN to abort the sequence on a press
// during LIGHTS or HOLD. Without it, those presses are ignored and
// jump_start stays 0.
//
// state  | meaning
// IDLE   | waiting for trigger
// LIGHTS | stepping the eight lights on, one per tick
// HOLD   | all lights lit, random hold delay running
// REACT  | lights out, counting cycles until press
module f1_sequencer #(
  parameter int TICK_DIV = 16,
  parameter int REACT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               trigger,
  input  logic               press,
  output logic               light_en,
  output logic               light_clr,
  output logic               busy,
  output logic               react_valid,
  output logic [REACT_W-1:0] react_time,
  output logic               jump_start
);

  localparam int                 TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0]      TICK_LOAD = TW'(TICK_DIV - 1);
  localparam logic [REACT_W-1:0] RMAX      = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LIGHTS = 2'd1,
    HOLD   = 2'd2,
    REACT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic [3:0]         step_q, step_d;
  logic [6:0]         hcnt_q, hcnt_d;
  logic [REACT_W-1:0] rcnt_q, rcnt_d;
  logic [REACT_W-1:0] react_time_d;
  logic [6:0]         lfsr_q;
  logic               light_en_d, light_clr_d, react_valid_d, busy_d;
  logic               tick;
`ifdef F1_SEQ_JUMP_START_EN
  logic               jump_d;
`endif

  // x^7 + x^6 + 1; a nonzero seed keeps it out of the all-zero lockup state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 7'h01;
    else        lfsr_q <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
  end

  assign tick = (tcnt_q == '0);

  always_comb begin
    state_d       = state_q;
    tcnt_d        = tcnt_q;
    step_d        = step_q;
    hcnt_d        = hcnt_q;
    rcnt_d        = rcnt_q;
    react_time_d  = react_time;
    light_en_d    = 1'b0;
    light_clr_d   = 1'b0;
    react_valid_d = 1'b0;
`ifdef F1_SEQ_JUMP_START_EN
    jump_d        = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d     = LIGHTS;
          light_clr_d = 1'b1;
          step_d      = 4'd0;
          tcnt_d      = TICK_LOAD;
        end
      end
      LIGHTS: begin
        if (tick) begin
          light_en_d = 1'b1;
          step_d     = step_q + 4'd1;
          tcnt_d     = TICK_LOAD;
          if (step_q == 4'd7) begin
            state_d = HOLD;
            hcnt_d  = lfsr_q;
          end
        end else begin
          tcnt_d = tcnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (tick) begin
          hcnt_d = hcnt_q - 7'd1;
          tcnt_d = TICK_LOAD;
          // The ninth advance wraps the light FSM from all-on to all-off.
          if (hcnt_q == 7'd1) begin
            light_en_d = 1'b1;
            rcnt_d     = '0;
            state_d    = REACT;
          end
        end else begin
          tcnt_d = tcnt_q - 1'b1;
        end
      end
      REACT: begin
        if (press) begin
          // The press cycle itself counts, so the result is rcnt + 1.
          react_time_d  = (rcnt_q == RMAX) ? RMAX : rcnt_q + 1'b1;
          react_valid_d = 1'b1;
          state_d       = IDLE;
        end else if (rcnt_q != RMAX) begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef F1_SEQ_JUMP_START_EN
    // An early press overrides any tick in the same cycle. Clearing the light
    // FSM leaves it all-off, ready for the next start.
    if (press && (state_q == LIGHTS || state_q == HOLD)) begin
      state_d     = IDLE;
      light_en_d  = 1'b0;
      light_clr_d = 1'b1;
      jump_d      = 1'b1;
    end
`endif

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tcnt_q      <= '0;
      step_q      <= '0;
      hcnt_q      <= '0;
      rcnt_q      <= '0;
      react_time  <= '0;
      light_en    <= 1'b0;
      light_clr   <= 1'b0;
      busy        <= 1'b0;
      react_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      step_q      <= step_d;
      hcnt_q      <= hcnt_d;
      rcnt_q      <= rcnt_d;
      react_time  <= react_time_d;
      light_en    <= light_en_d;
      light_clr   <= light_clr_d;
      busy        <= busy_d;
      react_valid <= react_valid_d;
    end
  end

`ifdef F1_SEQ_JUMP_START_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) jump_start <= 1'b0;
    else        jump_start <= jump_d;
  end
`else
  assign jump_start = 1'b0;
`endif

endmodule

// File: tb/tb_f1_sequencer.sv
// Directed and randomized bench for f1_sequencer with TICK_DIV=4 and
// REACT_W=16. The expected timeline of each sequence is computed from the
// trigger edge and the hold length H, using plain arithmetic.
module tb_f1_sequencer;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trigger = 1'b0;
  logic        press = 1'b0;
  logic        light_en, light_clr, busy, react_valid, jump_start;
  logic [15:0] react_time;

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;
  logic [15:0] last_rt = '0;

  f1_sequencer #(.TICK_DIV(TD), .REACT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .press(press),
    .light_en(light_en), .light_clr(light_clr), .busy(busy),
    .react_valid(react_valid), .react_time(react_time),
    .jump_start(jump_start)
  );

  always #5 clk = ~clk;

  // LFSR value after n shifts from the seed 7'h01 (x^7 + x^6 + 1).
  function automatic logic [6:0] lfsr_at(input int n);
    logic [6:0] v;
    v = 7'h01;
    for (int i = 0; i < n; i++) v = {v[5:0], v[6] ^ v[5]};
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp_v, edge_n);
    end
  endtask

  // Advance one rising edge and settle; the edge count restarts at each reset release.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) edge_n++;
  endtask

  function automatic logic [31:0] ctl();
    return 32'({light_en, light_clr, busy, react_valid, jump_start});
  endfunction

  // One full sequence. The trigger is sampled at the next edge k.
  // d: the press is sampled d edges after the lights-out edge.
  task automatic run_sequence(input int d, input bit press_with_trig,
                              input bit hold_press, input int spike_off);
    int k, h, lo, last, nxt;
    logic en_x, clr_x, busy_x, rv_x;
    logic [15:0] rt_x;
    k    = edge_n + 1;
    h    = int'(lfsr_at(k + 31));
    lo   = k + TD * (8 + h);
    last = lo + d;
    trigger = 1'b1;
    press   = press_with_trig;
    for (int e = k; e <= last; e++) begin
      tick();
      en_x   = ((e - k) % TD == 0 && e - k >= TD && e - k <= 8 * TD) || (e == lo);
      clr_x  = (e == k);
      busy_x = (e < last);
      rv_x   = (e == last);
      check("ctl", ctl(), 32'({en_x, clr_x, busy_x, rv_x, 1'b0}));
      if (e == last) last_rt = (d > 65535) ? 16'hFFFF : 16'(d);
      rt_x = last_rt;
      if (e == k || e == lo || e == last) check("react_time", 32'(react_time), 32'(rt_x));
      trigger = 1'($urandom_range(0, 1));
      nxt = e + 1;
      if (nxt == last)                                press = 1'b1;
      else if (nxt > lo)                              press = 1'b0;
`ifndef F1_SEQ_JUMP_START_EN
      else if (hold_press && nxt >= lo - 3)           press = 1'b1;
      else if (spike_off != 0 && nxt == k + spike_off) press = 1'b1;
      else                                            press = 1'($urandom_range(0, 1));
`else
      else                                            press = 1'b0;
`endif
    end
    trigger = 1'b0;
    press   = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, miscompares %0d", miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset, then stay idle; presses here must be ignored.
    #23;
    check("reset_ctl", ctl(), 32'd0);
    check("reset_rt", 32'(react_time), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    edge_n = 0;
    for (int i = 0; i < 9; i++) begin
      press = 1'($urandom_range(0, 1));
      tick();
      check("idle_ctl", ctl(), 32'd0);
    end
    press = 1'b0;

    // The trigger is sampled at edge 10; the press comes 25 cycles after lights-out.
    run_sequence(25, 1'b0, 1'b0, 0);
    repeat (3) tick();

    // Trigger and press together in IDLE, with a random reaction delay.
    run_sequence(int'($urandom_range(2, 300)), 1'b1, 1'b0, 0);
    tick();

    // A press after the third light pulse.
`ifdef F1_SEQ_JUMP_START_EN
    k = edge_n + 1;
    trigger = 1'b1;
    for (int e = k; e <= k + 13; e++) begin
      tick();
      trigger = 1'b0;
      if (e == k + 12) press = 1'b1;
    end
    press = 1'b0;
    check("jump_ctl", ctl(), 32'b01001);
    check("jump_rt", 32'(react_time), 32'(last_rt));
    for (int i = 0; i < 40; i++) begin
      tick();
      check("post_jump_ctl", ctl(), 32'd0);
    end
`else
    k = 0;
    run_sequence(int'($urandom_range(2, 100)), 1'b0, 1'b0, 13);
`endif
    tick();

    // The press is held high across lights-out, so react_time must be 1.
    run_sequence(1, 1'b0, 1'b1, 0);
    tick();

    // No press for 70000 cycles: react_time saturates.
    run_sequence(70001, 1'b0, 1'b0, 0);
    tick();

    // Reset during HOLD with trigger held high.
    k = edge_n + 1;
    trigger = 1'b1;
    press = 1'b0;
    for (int e = k; e <= k + 34; e++) tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_ctl", ctl(), 32'd0);
    check("async_rst_rt", 32'(react_time), 32'd0);
    last_rt = '0;
    @(posedge clk);
    #1;
    check("in_rst_ctl", ctl(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    edge_n = 0;
    run_sequence(int'($urandom_range(2, 200)), 1'b0, 1'b0, 0);
    repeat (2) tick();
    check("final_ctl", ctl(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/f1_sequencer.md
# f1_sequencer

Controller for the F1 start-light FSM: on a start trigger it steps the eight lights on at a fixed tick rate, holds all lights for a pseudo-random delay, then extinguishes them and measures the driver's reaction time in clock cycles. It drives the light FSM's `en` and `rst` inputs. It also detects a button press before lights-out (jump start). All outputs are registered.

## Interface
- `TICK_DIV`, default 16: clock cycles per light step and per hold unit; legal values are ≥ 2.
- `REACT_W`, default 16: width of the reaction-time counter and result.
- `clk`  in  1  system clock; all logic runs on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `trigger`  in  1  start request, level-sampled, honoured only in IDLE.
- `press`  in  1  driver button, level-sampled, synchronous to `clk`.
- `light_en`  out  1  one-cycle pulse that advances the light FSM by one state.
- `light_clr`  out  1  one-cycle pulse that clears the light FSM to S0 (all off).
- `busy`  out  1  high whenever state ≠ IDLE.
- `react_valid`  out  1  one-cycle pulse; `react_time` is updated in the same cycle.
- `react_time`  out  REACT_W  last measured reaction time; held until the next measurement.
- `jump_start`  out  1  one-cycle pulse when a sequence is aborted by an early press.

## Operation
- States:
  - IDLE: waits for a start.
  - LIGHTS: turns the lights on one step at a time.
  - HOLD: all eight lights lit, random delay running.
  - REACT: lights out, timing the driver.
- Tick counter `tcnt`:
  - Loaded with TICK_DIV-1 on entry to LIGHTS and on each tick.
  - Decrements every cycle in LIGHTS and HOLD.
  - A tick occurs at the edge where `tcnt` == 0.
- Step counter `step`: 4 bits.
- Hold counter `hcnt`: 7 bits.
- LFSR: 7-bit Fibonacci, polynomial x^7+x^6+1, reset seed 7'h01. It shifts every cycle regardless of state and is never zero.
- IDLE → LIGHTS when `trigger`=1:
  - `light_clr` pulses.
  - `step` ← 0.
  - `tcnt` ← TICK_DIV-1.
- LIGHTS:
  - On each tick, `light_en` pulses and `step` increments.
  - On the tick that makes `step` = 8, go to HOLD and load `hcnt` ← current LFSR value (1..127).
- HOLD:
  - On each tick, `hcnt` decrements.
  - On the tick where `hcnt` == 1, `light_en` pulses (the light FSM wraps S8→S0, lights out), the reaction counter `rcnt` ← 0, and state goes to REACT.
- REACT:
  - With `press`=0, `rcnt` increments each cycle and saturates at 2^REACT_W-1.
  - With `press`=1:
    - `react_time` ← min(`rcnt`+1, 2^REACT_W-1).
    - `react_valid` pulses.
    - State goes to IDLE.
- Total `light_en` pulses per completed sequence: exactly 9.
- `trigger` outside IDLE is ignored; it is not queued.
- `press` in IDLE is ignored.
- Simultaneous `trigger` and `press` in IDLE: start the sequence; the press is not a jump start.
- `press` held high at REACT entry gives `react_time` = 1.

## Timing
- Reset values:
  - state IDLE.
  - `light_en`, `light_clr`, `busy`, `react_valid`, `jump_start` = 0.
  - `react_time` = 0.
  - LFSR = 7'h01.
  - `tcnt`, `step`, `hcnt`, `rcnt` = 0.
- `trigger` sampled high at edge k:
  - `light_clr`=1 and `busy`=1 in the cycle after edge k.
  - Light pulses follow edges k+n·TICK_DIV for n = 1..8.
  - The lights-out pulse follows edge k+(8+H)·TICK_DIV, where H is the LFSR value sampled at HOLD entry.
- `press` sampled at edge m in REACT: `react_valid` is high in the cycle after m and `busy` falls in that same cycle.
- Mid-operation reset: all state and outputs return to reset values asynchronously. No pulse is emitted on reset release.

## Configuration
- Macro: `F1_SEQ_JUMP_START_EN`.
- Defined: `press`=1 in LIGHTS or HOLD aborts the sequence.
  - `jump_start` and `light_clr` pulse together in the next cycle.
  - State goes to IDLE.
  - `react_time` is unchanged.
- Not defined:
  - `press` is ignored outside REACT.
  - `jump_start` is tied to 0.

## Test plan
All scenarios use TICK_DIV=4 and REACT_W=16.
- Reset then trigger at edge 10 → `light_clr` pulse after edge 10; `light_en` pulses after edges 14, 18, …, 42; `busy`=1 throughout.
- Full sequence with H taken from the LFSR model → 9th `light_en` after edge 42+4H. Press 25 cycles later → `react_time`=25 with a single `react_valid` pulse.
- REACT with `press` never asserted for 70000 cycles, then press → `react_time`=16'hFFFF.
- With `F1_SEQ_JUMP_START_EN`, press after the 3rd light pulse → `jump_start`=1 and `light_clr`=1 for one cycle, `busy`=0, no further `light_en`. Without the macro → the sequence completes normally.
- `trigger` held high throughout, plus `rst_n` pulled low during HOLD → all outputs 0 immediately. After release, a new sequence starts on the first edge with `trigger` high.
- `press` held high across lights-out (macro undefined) → `react_time`=1.
